rvc_fetch_aligner: RTL

Sequential front-end stage between instruction fetch and decode. Accepts word-aligned 32-bit fetch words in program order, buffers them as a halfword queue, and realigns mixed 16/32-bit instruction streams, including 32-bit instructions that straddle a word boundary. Each compressed instruction is expanded to its RV32I equivalent, so decode sees one 32-bit instruction per handshake with its PC. It adds buffering, PC tracking, redirect/flush and the full RV32C integer subset.

---
 rtl/rvc_fetch_aligner.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rvc_fetch_aligner.sv
// Fetch-to-decode aligner: queues 32-bit fetch words as halfwords, extracts
// one 16- or 32-bit instruction per handshake (including instructions that
// straddle a fetch word), expands RV32C to RV32I and tracks the PC.
module rvc_fetch_aligner #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_rvc,
  output logic        out_illegal,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LIMIT = (AW+1)'(DEPTH - 2);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_pc;
  logic          r_drop_first;

  logic [15:0]   w_h0, w_h1;
  logic          w_is32, w_nonempty, w_complete, w_push, w_pop;
  logic [1:0]    w_push_cnt, w_pop_cnt;
  logic [31:0]   w_exp_inst;
  logic          w_exp_illegal;
  logic          w_flush_pc_unused;

  // Halfword-aligned redirect: the byte bit of the target has no meaning.
  assign w_flush_pc_unused = flush_pc[0];

  assign w_h0       = r_mem[r_rd_ptr];
  assign w_h1       = r_mem[r_rd_ptr + AW'(1)];
  assign w_is32     = (w_h0[1:0] == 2'b11);
  assign w_nonempty = (r_count != '0);
  assign w_complete = w_is32 ? (r_count >= (AW+1)'(2)) : w_nonempty;

  // Readiness looks only at the registered count, never at a same-cycle pop.
  assign in_ready  = (r_count <= FULL_LIMIT) && !flush_valid;
  assign out_valid = w_complete && !flush_valid;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_push_cnt = w_push ? (r_drop_first ? 2'd1 : 2'd2) : 2'd0;
  assign w_pop_cnt  = w_pop  ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;

  assign out_pc      = r_pc;
  assign out_rvc     = w_nonempty && !w_is32;
  assign out_illegal = w_nonempty && !w_is32 && w_exp_illegal;
  assign out_inst    = !w_nonempty ? 32'h0 : (w_is32 ? {w_h1, w_h0} : w_exp_inst);

  // Write the incoming halfwords at the tail; a mid-word redirect skips the low half.
  // NOTE: queue storage has no reset; the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      if (r_drop_first) begin
        r_mem[r_wr_ptr] <= in_data[31:16];
      end else begin
        r_mem[r_wr_ptr]          <= in_data[15:0];
        r_mem[r_wr_ptr + AW'(1)] <= in_data[31:16];
      end
    end
  end

  // Pointer, count, PC and drop-first bookkeeping; a flush overrides push and pop.
  // NOTE: non-blocking assignments so every register sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pc         <= RESET_PC;
      r_drop_first <= RESET_PC[1];
    end else if (flush_valid) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pc         <= {flush_pc[31:1], 1'b0};
      r_drop_first <= flush_pc[1];
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_cnt);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_cnt);
      r_count  <= r_count + (AW+1)'(w_push_cnt) - (AW+1)'(w_pop_cnt);
      if (w_pop)  r_pc <= r_pc + (w_is32 ? 32'd4 : 32'd2);
      if (w_push) r_drop_first <= 1'b0;
    end
  end

  // Compressed operand fields and immediates, sign-extended to 12 bits where signed.
  logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
  logic [11:0] w_imm6, w_lw_imm, w_a4_imm, w_a16_imm, w_lwsp_imm, w_swsp_imm;
  logic [20:0] w_j_imm;
  logic [12:0] w_b_imm;
  logic [19:0] w_lui_imm;
  logic [2:0]  w_alu_f3;

  assign w_rd       = w_h0[11:7];
  assign w_rs2      = w_h0[6:2];
  assign w_rdp      = {2'b01, w_h0[4:2]};
  assign w_rs1p     = {2'b01, w_h0[9:7]};
  assign w_imm6     = {{6{w_h0[12]}}, w_h0[12], w_h0[6:2]};
  assign w_lui_imm  = {{14{w_h0[12]}}, w_h0[12], w_h0[6:2]};
  assign w_lw_imm   = {5'b0, w_h0[5], w_h0[12:10], w_h0[6], 2'b00};
  assign w_a4_imm   = {2'b0, w_h0[10:7], w_h0[12:11], w_h0[5], w_h0[6], 2'b00};
  assign w_a16_imm  = {{3{w_h0[12]}}, w_h0[4:3], w_h0[5], w_h0[2], w_h0[6], 4'b0};
  assign w_lwsp_imm = {4'b0, w_h0[3:2], w_h0[12], w_h0[6:4], 2'b00};
  assign w_swsp_imm = {4'b0, w_h0[8:7], w_h0[12:9], 2'b00};
  assign w_j_imm    = {{10{w_h0[12]}}, w_h0[8], w_h0[10:9], w_h0[6], w_h0[7],
                       w_h0[2], w_h0[11], w_h0[5:3], 1'b0};
  assign w_b_imm    = {{5{w_h0[12]}}, w_h0[6:5], w_h0[2], w_h0[11:10], w_h0[4:3], 1'b0};

  // SUB/XOR/OR/AND select by funct2 in bits [6:5].
  always_comb begin
    w_alu_f3 = 3'b000;
    case (w_h0[6:5])
      2'b00:   w_alu_f3 = 3'b000;
      2'b01:   w_alu_f3 = 3'b100;
      2'b10:   w_alu_f3 = 3'b110;
      default: w_alu_f3 = 3'b111;
    endcase
  end

  // RV32C to RV32I expansion keyed on {quadrant, funct3}; reserved forms flag illegal.
  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    w_exp_inst    = 32'h0;
    w_exp_illegal = 1'b0;
    case ({w_h0[1:0], w_h0[15:13]})
      5'b00_000: if (w_a4_imm == '0) w_exp_illegal = 1'b1;
                 else w_exp_inst = {w_a4_imm, 5'd2, 3'b000, w_rdp, 7'b0010011};
      5'b00_010: w_exp_inst = {w_lw_imm, w_rs1p, 3'b010, w_rdp, 7'b0000011};
      5'b00_110: w_exp_inst = {w_lw_imm[11:5], w_rdp, w_rs1p, 3'b010, w_lw_imm[4:0], 7'b0100011};
      5'b01_000: w_exp_inst = {w_imm6, w_rd, 3'b000, w_rd, 7'b0010011};
      5'b01_001: w_exp_inst = {w_j_imm[20], w_j_imm[10:1], w_j_imm[11], w_j_imm[19:12],
                               5'd1, 7'b1101111};
      5'b01_010: w_exp_inst = {w_imm6, 5'd0, 3'b000, w_rd, 7'b0010011};
      5'b01_011: begin
        if (w_rd == 5'd2) begin
          if (w_a16_imm == '0) w_exp_illegal = 1'b1;
          else w_exp_inst = {w_a16_imm, 5'd2, 3'b000, 5'd2, 7'b0010011};
        end else if (w_imm6 == '0) begin
          w_exp_illegal = 1'b1;
        end else begin
          w_exp_inst = {w_lui_imm, w_rd, 7'b0110111};
        end
      end
      5'b01_100: begin
        case (w_h0[11:10])
          2'b00, 2'b01: if (w_h0[12]) w_exp_illegal = 1'b1;
                        else w_exp_inst = {1'b0, w_h0[10], 5'b0, w_h0[6:2], w_rs1p, 3'b101,
                                           w_rs1p, 7'b0010011};
          2'b10:        w_exp_inst = {w_imm6, w_rs1p, 3'b111, w_rs1p, 7'b0010011};
          default:      if (w_h0[12]) w_exp_illegal = 1'b1;
                        else w_exp_inst = {1'b0, (w_h0[6:5] == 2'b00), 5'b0, w_rdp, w_rs1p,
                                           w_alu_f3, w_rs1p, 7'b0110011};
        endcase
      end
      5'b01_101: w_exp_inst = {w_j_imm[20], w_j_imm[10:1], w_j_imm[11], w_j_imm[19:12],
                               5'd0, 7'b1101111};
      5'b01_110, 5'b01_111:
                 w_exp_inst = {w_b_imm[12], w_b_imm[10:5], 5'd0, w_rs1p, 2'b00, w_h0[13],
                               w_b_imm[4:1], w_b_imm[11], 7'b1100011};
      5'b10_000: if (w_h0[12]) w_exp_illegal = 1'b1;
                 else w_exp_inst = {7'b0, w_h0[6:2], w_rd, 3'b001, w_rd, 7'b0010011};
      5'b10_010: if (w_rd == 5'd0) w_exp_illegal = 1'b1;
                 else w_exp_inst = {w_lwsp_imm, 5'd2, 3'b010, w_rd, 7'b0000011};
      5'b10_100: begin
        if (!w_h0[12]) begin
          if (w_rs2 != 5'd0)     w_exp_inst = {7'b0, w_rs2, 5'd0, 3'b000, w_rd, 7'b0110011};
          else if (w_rd == 5'd0) w_exp_illegal = 1'b1;
          else                   w_exp_inst = {12'b0, w_rd, 3'b000, 5'd0, 7'b1100111};
        end else begin
          if (w_rs2 != 5'd0)     w_exp_inst = {7'b0, w_rs2, w_rd, 3'b000, w_rd, 7'b0110011};
          else if (w_rd == 5'd0) w_exp_inst = 32'h0010_0073;
          else                   w_exp_inst = {12'b0, w_rd, 3'b000, 5'd1, 7'b1100111};
        end
      end
      5'b10_110: w_exp_inst = {w_swsp_imm[11:5], w_rs2, 5'd2, 3'b010, w_swsp_imm[4:0], 7'b0100011};
      default:   w_exp_illegal = 1'b1;
    endcase
    if (w_exp_illegal) w_exp_inst = 32'h0;
  end

endmodule
